multicycle_control: RTL and testbench

Parametrised multi-cycle control unit for the MIPS core. It replaces the single-cycle opcode decoder with a state machine that sequences fetch, decode, execute, memory and write-back over several clocks. It stalls on a memory ready handshake and traps memory timeouts. It sits between the instruction register (opcode source) and the datapath muxes, register file, PC and unified memory.

---
 rtl/multicycle_control.sv | 217 +++++++++++++++++++++
 tb/tb_multicycle_control.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_control
// Purpose  : Multi-cycle MIPS control FSM (fetch/decode/exec/mem/wb) with a
//            memory-ready handshake and a memory timeout trap.
// Revision : 1.0
// ============================================================================
module multicycle_control #(
    parameter int ALU_OP_W       = 4,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [5:0]          opcode_i,
    input  logic                mem_ready_i,
    output logic                pc_write_o,
    output logic                pc_write_cond_eq_o,
    output logic                pc_write_cond_ne_o,
    output logic [1:0]          pc_source_o,
    output logic                i_or_d_o,
    output logic                mem_read_o,
    output logic                mem_write_o,
    output logic                ir_write_o,
    output logic                reg_dst_o,
    output logic                mem_to_reg_o,
    output logic                reg_write_o,
    output logic                link_o,
    output logic                alu_src_a_o,
    output logic [1:0]          alu_src_b_o,
    output logic [ALU_OP_W-1:0] alu_op_o,
    output logic                illegal_o,
    output logic                bus_err_o,
    output logic [2:0]          state_o
);

    localparam logic [2:0] c_FETCH  = 3'd0;
    localparam logic [2:0] c_DECODE = 3'd1;
    localparam logic [2:0] c_EXEC   = 3'd2;
    localparam logic [2:0] c_MEM    = 3'd3;
    localparam logic [2:0] c_WB     = 3'd4;
    localparam logic [2:0] c_ERROR  = 3'd7;

    localparam logic [5:0] c_OP_R    = 6'h00;
    localparam logic [5:0] c_OP_J    = 6'h02;
    localparam logic [5:0] c_OP_JAL  = 6'h03;
    localparam logic [5:0] c_OP_BEQ  = 6'h04;
    localparam logic [5:0] c_OP_BNE  = 6'h05;
    localparam logic [5:0] c_OP_ADDI = 6'h08;
    localparam logic [5:0] c_OP_ANDI = 6'h0c;
    localparam logic [5:0] c_OP_ORI  = 6'h0d;
    localparam logic [5:0] c_OP_LUI  = 6'h0f;
    localparam logic [5:0] c_OP_LW   = 6'h23;
    localparam logic [5:0] c_OP_SW   = 6'h2b;

    // A zero timeout would give a zero-width counter; keep at least one bit.
    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] c_TO_LAST =
        (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

    logic [2:0]       state_q,    state_d;
    logic [5:0]       opcode_q,   opcode_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             w_wait;
    logic             w_expire;

    function automatic logic [3:0] alu_code(input logic [5:0] op);
        logic [3:0] code;
        case (op)
            c_OP_R:    code = 4'b1111;
            c_OP_ADDI: code = 4'b0000;
            c_OP_ORI:  code = 4'b0001;
            c_OP_LUI:  code = 4'b0010;
            c_OP_ANDI: code = 4'b0011;
            c_OP_LW:   code = 4'b0100;
            c_OP_SW:   code = 4'b0101;
            c_OP_BEQ:  code = 4'b0110;
            c_OP_BNE:  code = 4'b0111;
            default:   code = 4'b0000;
        endcase
        return code;
    endfunction

    function automatic logic is_exec_op(input logic [5:0] op);
        logic ok;
        case (op)
            c_OP_R, c_OP_ADDI, c_OP_ORI, c_OP_LUI, c_OP_ANDI,
            c_OP_LW, c_OP_SW, c_OP_BEQ, c_OP_BNE: ok = 1'b1;
            default:                              ok = 1'b0;
        endcase
        return ok;
    endfunction

    assign w_wait   = ((state_q == c_FETCH) || (state_q == c_MEM)) && !mem_ready_i;
    assign w_expire = (TIMEOUT_CYCLES != 0) && w_wait && (wait_cnt_q == c_TO_LAST);

    // Counter only runs while stalled in place, so any transition clears it.
    assign wait_cnt_d = (w_wait && !w_expire) ? wait_cnt_q + 1'b1 : '0;
    assign opcode_d   = (state_q == c_DECODE) ? opcode_i : opcode_q;

    always_comb begin
        state_d = c_FETCH;
        case (state_q)
            c_FETCH:  state_d = mem_ready_i ? c_DECODE : c_FETCH;
            c_DECODE: state_d = is_exec_op(opcode_i) ? c_EXEC : c_FETCH;
            c_EXEC: begin
                if (opcode_q == c_OP_LW || opcode_q == c_OP_SW) begin
                    state_d = c_MEM;
                end else if (opcode_q == c_OP_BEQ || opcode_q == c_OP_BNE) begin
                    state_d = c_FETCH;
                end else begin
                    state_d = c_WB;
                end
            end
            c_MEM: begin
                if (!mem_ready_i) begin
                    state_d = c_MEM;
                end else if (opcode_q == c_OP_LW) begin
                    state_d = c_WB;
                end else begin
                    state_d = c_FETCH;
                end
            end
            c_WB:     state_d = c_FETCH;
            c_ERROR:  state_d = c_ERROR;
            default:  state_d = c_FETCH;
        endcase
        if (w_expire) begin
            state_d = c_ERROR;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= c_FETCH;
            opcode_q   <= 6'h00;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            opcode_q   <= opcode_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    always_comb begin
        pc_write_o         = 1'b0;
        pc_write_cond_eq_o = 1'b0;
        pc_write_cond_ne_o = 1'b0;
        pc_source_o        = 2'b00;
        i_or_d_o           = 1'b0;
        mem_read_o         = 1'b0;
        mem_write_o        = 1'b0;
        ir_write_o         = 1'b0;
        reg_dst_o          = 1'b0;
        mem_to_reg_o       = 1'b0;
        reg_write_o        = 1'b0;
        link_o             = 1'b0;
        alu_src_a_o        = 1'b0;
        alu_src_b_o        = 2'b00;
        alu_op_o           = '0;
        illegal_o          = 1'b0;
        bus_err_o          = 1'b0;
        // Reset low masks everything immediately, not at the next edge.
        if (reset) begin
            case (state_q)
                c_FETCH: begin
                    mem_read_o  = 1'b1;
                    alu_src_b_o = 2'b01;
                    ir_write_o  = mem_ready_i;
                    pc_write_o  = mem_ready_i;
                end
                c_DECODE: begin
                    alu_src_b_o = 2'b11;
                    if (opcode_i == c_OP_J || opcode_i == c_OP_JAL) begin
                        pc_write_o  = 1'b1;
                        pc_source_o = 2'b10;
                        reg_write_o = (opcode_i == c_OP_JAL);
                        link_o      = (opcode_i == c_OP_JAL);
                    end else if (!is_exec_op(opcode_i)) begin
                        illegal_o = 1'b1;
                    end
                end
                c_EXEC: begin
                    alu_src_a_o = 1'b1;
                    alu_op_o    = ALU_OP_W'(alu_code(opcode_q));
                    case (opcode_q)
                        c_OP_BEQ: begin
                            pc_write_cond_eq_o = 1'b1;
                            pc_source_o        = 2'b01;
                        end
                        c_OP_BNE: begin
                            pc_write_cond_ne_o = 1'b1;
                            pc_source_o        = 2'b01;
                        end
                        c_OP_R:  alu_src_b_o = 2'b00;
                        default: alu_src_b_o = 2'b10;
                    endcase
                end
                c_MEM: begin
                    i_or_d_o    = 1'b1;
                    mem_read_o  = (opcode_q == c_OP_LW);
                    mem_write_o = (opcode_q == c_OP_SW);
                end
                c_WB: begin
                    reg_write_o  = 1'b1;
                    reg_dst_o    = (opcode_q == c_OP_R);
                    mem_to_reg_o = (opcode_q == c_OP_LW);
                end
                c_ERROR:  bus_err_o = 1'b1;
                default: ;
            endcase
        end
    end

    assign state_o = state_q;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_control
// Purpose  : Directed self-checking bench for multicycle_control.
// Revision : 1.0
// ============================================================================
module tb_multicycle_control;

    logic       clk;
    logic       reset;
    logic [5:0] opcode_i;
    logic       mem_ready_i;
    logic       pc_write_o, pc_write_cond_eq_o, pc_write_cond_ne_o;
    logic [1:0] pc_source_o;
    logic       i_or_d_o, mem_read_o, mem_write_o, ir_write_o;
    logic       reg_dst_o, mem_to_reg_o, reg_write_o, link_o;
    logic       alu_src_a_o;
    logic [1:0] alu_src_b_o;
    logic [3:0] alu_op_o;
    logic       illegal_o, bus_err_o;
    logic [2:0] state_o;

    int n_cmp = 0;
    int n_err = 0;

    multicycle_control #(.ALU_OP_W(4), .TIMEOUT_CYCLES(15)) dut (
        .clk                (clk),
        .reset              (reset),
        .opcode_i           (opcode_i),
        .mem_ready_i        (mem_ready_i),
        .pc_write_o         (pc_write_o),
        .pc_write_cond_eq_o (pc_write_cond_eq_o),
        .pc_write_cond_ne_o (pc_write_cond_ne_o),
        .pc_source_o        (pc_source_o),
        .i_or_d_o           (i_or_d_o),
        .mem_read_o         (mem_read_o),
        .mem_write_o        (mem_write_o),
        .ir_write_o         (ir_write_o),
        .reg_dst_o          (reg_dst_o),
        .mem_to_reg_o       (mem_to_reg_o),
        .reg_write_o        (reg_write_o),
        .link_o             (link_o),
        .alu_src_a_o        (alu_src_a_o),
        .alu_src_b_o        (alu_src_b_o),
        .alu_op_o           (alu_op_o),
        .illegal_o          (illegal_o),
        .bus_err_o          (bus_err_o),
        .state_o            (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b0; opcode_i = 6'h00; mem_ready_i = 1'b0;
        #2;
        n_cmp++;
        if (state_o !== 3'd0 || bus_err_o !== 1'b0 || illegal_o !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state: state=%0d bus_err=%b illegal=%b want 0/0/0", state_o, bus_err_o, illegal_o);
        end
        n_cmp++;
        if (mem_read_o !== 1'b0) begin
            n_err++;
            $display("FAIL reset_strobe: mem_read=%b want 0", mem_read_o);
        end
        tick; tick;
        reset = 1'b1;
        #1;
        n_cmp++;
        if (mem_read_o !== 1'b1 || state_o !== 3'd0) begin
            n_err++;
            $display("FAIL release_fetch: mem_read=%b state=%0d want 1/0", mem_read_o, state_o);
        end
    endtask

    task automatic test_addi;
        opcode_i = 6'h08; mem_ready_i = 1'b1;
        #1;
        n_cmp++;
        if (ir_write_o !== 1'b1 || pc_write_o !== 1'b1 || alu_src_b_o !== 2'b01) begin
            n_err++;
            $display("FAIL addi_fetch: ir_write=%b pc_write=%b srcb=%b want 1/1/01", ir_write_o, pc_write_o, alu_src_b_o);
        end
        tick;
        n_cmp++;
        if (state_o !== 3'd1 || alu_src_b_o !== 2'b11) begin
            n_err++;
            $display("FAIL addi_decode: state=%0d srcb=%b want 1/11", state_o, alu_src_b_o);
        end
        tick;
        opcode_i = 6'h2b;  // late opcode change must not redirect the ADDI
        #1;
        n_cmp++;
        if (state_o !== 3'd2 || alu_op_o !== 4'b0000 || alu_src_b_o !== 2'b10 || alu_src_a_o !== 1'b1) begin
            n_err++;
            $display("FAIL addi_exec: state=%0d aluop=%b srcb=%b srca=%b want 2/0000/10/1", state_o, alu_op_o, alu_src_b_o, alu_src_a_o);
        end
        tick;
        n_cmp++;
        if (state_o !== 3'd4 || reg_write_o !== 1'b1 || reg_dst_o !== 1'b0 || mem_to_reg_o !== 1'b0) begin
            n_err++;
            $display("FAIL addi_wb: state=%0d reg_write=%b reg_dst=%b m2r=%b want 4/1/0/0", state_o, reg_write_o, reg_dst_o, mem_to_reg_o);
        end
        tick;
        n_cmp++;
        if (state_o !== 3'd0) begin
            n_err++;
            $display("FAIL addi_done: state=%0d want 0", state_o);
        end
    endtask

    task automatic test_lw_wait;
        int cycles;
        int held;
        opcode_i = 6'h23; mem_ready_i = 1'b1;
        cycles = 0; held = 0;
        tick; cycles++;
        mem_ready_i = 1'b0;  // ignored in DECODE/EXEC
        tick; cycles++;
        n_cmp++;
        if (state_o !== 3'd2 || alu_op_o !== 4'b0100 || alu_src_b_o !== 2'b10) begin
            n_err++;
            $display("FAIL lw_exec: state=%0d aluop=%b srcb=%b want 2/0100/10", state_o, alu_op_o, alu_src_b_o);
        end
        tick; cycles++;
        for (int i = 0; i < 4; i++) begin
            mem_ready_i = (i == 3);
            #1;
            if (state_o == 3'd3 && mem_read_o === 1'b1 && i_or_d_o === 1'b1 && mem_write_o === 1'b0) held++;
            tick; cycles++;
        end
        mem_ready_i = 1'b0;
        n_cmp++;
        if (held != 4) begin
            n_err++;
            $display("FAIL lw_mem_held: cycles=%0d want 4", held);
        end
        n_cmp++;
        if (state_o !== 3'd4 || mem_to_reg_o !== 1'b1 || reg_write_o !== 1'b1) begin
            n_err++;
            $display("FAIL lw_wb: state=%0d m2r=%b reg_write=%b want 4/1/1", state_o, mem_to_reg_o, reg_write_o);
        end
        tick; cycles++;
        n_cmp++;
        if (state_o !== 3'd0 || cycles != 8) begin
            n_err++;
            $display("FAIL lw_total: state=%0d cycles=%0d want 0/8", state_o, cycles);
        end
    endtask

    task automatic test_bne_jal;
        opcode_i = 6'h05; mem_ready_i = 1'b1;
        tick; tick;
        n_cmp++;
        if (state_o !== 3'd2 || pc_write_cond_ne_o !== 1'b1 || pc_write_cond_eq_o !== 1'b0
            || pc_source_o !== 2'b01 || alu_op_o !== 4'b0111) begin
            n_err++;
            $display("FAIL bne_exec: state=%0d ne=%b eq=%b src=%b aluop=%b want 2/1/0/01/0111",
                     state_o, pc_write_cond_ne_o, pc_write_cond_eq_o, pc_source_o, alu_op_o);
        end
        tick;
        n_cmp++;
        if (state_o !== 3'd0) begin
            n_err++;
            $display("FAIL bne_done: state=%0d want 0", state_o);
        end
        opcode_i = 6'h03;
        tick;
        n_cmp++;
        if (state_o !== 3'd1 || pc_write_o !== 1'b1 || pc_source_o !== 2'b10
            || reg_write_o !== 1'b1 || link_o !== 1'b1) begin
            n_err++;
            $display("FAIL jal_decode: state=%0d pcw=%b src=%b rw=%b link=%b want 1/1/10/1/1",
                     state_o, pc_write_o, pc_source_o, reg_write_o, link_o);
        end
        tick;
        n_cmp++;
        if (state_o !== 3'd0) begin
            n_err++;
            $display("FAIL jal_done: state=%0d want 0", state_o);
        end
    endtask

    task automatic test_illegal;
        int ill_cycles;
        int writes;
        opcode_i = 6'h3f; mem_ready_i = 1'b1;
        ill_cycles = 0; writes = 0;
        for (int i = 0; i < 3; i++) begin
            if (illegal_o === 1'b1) ill_cycles++;
            if (reg_write_o !== 1'b0 || mem_write_o !== 1'b0) writes++;
            if (i == 1 && state_o !== 3'd1) writes += 100;
            tick;
        end
        n_cmp++;
        if (ill_cycles != 1 || writes != 0) begin
            n_err++;
            $display("FAIL illegal_pulse: pulses=%0d bad=%0d want 1/0", ill_cycles, writes);
        end
        n_cmp++;
        if (state_o !== 3'd0 && state_o !== 3'd1) begin
            n_err++;
            $display("FAIL illegal_return: state=%0d want 0 or 1", state_o);
        end
        // three ticks with ready=1: FETCH,DECODE,FETCH -> now DECODE; finish it
        tick;
    endtask

    task automatic test_sw_late_ready;
        opcode_i = 6'h2b; mem_ready_i = 1'b1;
        n_cmp++;
        if (state_o !== 3'd0) begin
            n_err++;
            $display("FAIL sw_start: state=%0d want 0", state_o);
        end
        tick; tick; tick;
        for (int i = 0; i < 15; i++) begin
            mem_ready_i = (i == 14);
            #1;
            tick;
        end
        mem_ready_i = 1'b1;
        n_cmp++;
        if (state_o !== 3'd0 || bus_err_o !== 1'b0) begin
            n_err++;
            $display("FAIL sw_ready_wins: state=%0d bus_err=%b want 0/0", state_o, bus_err_o);
        end
    endtask

    task automatic test_reset_mid_mem;
        opcode_i = 6'h2b; mem_ready_i = 1'b1;
        tick; tick; tick;
        mem_ready_i = 1'b0;
        #1;
        n_cmp++;
        if (state_o !== 3'd3 || mem_write_o !== 1'b1) begin
            n_err++;
            $display("FAIL sw_mem: state=%0d mem_write=%b want 3/1", state_o, mem_write_o);
        end
        reset = 1'b0;
        #1;
        n_cmp++;
        if (mem_write_o !== 1'b0 || state_o !== 3'd0) begin
            n_err++;
            $display("FAIL reset_abort: mem_write=%b state=%0d want 0/0", mem_write_o, state_o);
        end
        tick;
        reset = 1'b1;
        #1;
    endtask

    task automatic test_timeout;
        mem_ready_i = 1'b0; opcode_i = 6'h00;
        n_cmp++;
        if (ir_write_o !== 1'b0 || mem_read_o !== 1'b1) begin
            n_err++;
            $display("FAIL fetch_stall: ir_write=%b mem_read=%b want 0/1", ir_write_o, mem_read_o);
        end
        for (int i = 0; i < 14; i++) tick;
        n_cmp++;
        if (state_o !== 3'd0) begin
            n_err++;
            $display("FAIL timeout_early: state=%0d want 0 after 14 waits", state_o);
        end
        tick;
        n_cmp++;
        if (state_o !== 3'd7 || bus_err_o !== 1'b1) begin
            n_err++;
            $display("FAIL timeout_trap: state=%0d bus_err=%b want 7/1", state_o, bus_err_o);
        end
        mem_ready_i = 1'b1;
        tick; tick;
        n_cmp++;
        if (state_o !== 3'd7 || bus_err_o !== 1'b1 || mem_read_o !== 1'b0) begin
            n_err++;
            $display("FAIL error_sticky: state=%0d bus_err=%b mem_read=%b want 7/1/0", state_o, bus_err_o, mem_read_o);
        end
        reset = 1'b0;
        #1;
        n_cmp++;
        if (state_o !== 3'd0 || bus_err_o !== 1'b0) begin
            n_err++;
            $display("FAIL error_reset: state=%0d bus_err=%b want 0/0", state_o, bus_err_o);
        end
        tick;
        reset = 1'b1;
        #1;
    endtask

    initial begin
        test_reset;
        test_addi;
        test_lw_wait;
        test_bne_jal;
        test_illegal;
        test_sw_late_ready;
        test_reset_mid_mem;
        test_timeout;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
